// File: rtl/riscv_pkg.sv
// riscv_pkg: shared register-file widths and the writeback request record
package riscv_pkg;
  localparam int XLEN = 32;
  localparam int REG_COUNT = 32;
  localparam int RW = $clog2(REG_COUNT);
  typedef struct packed {
    logic [RW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: in-order FIFO of writeback requests; ports: push/din, pop/dout, count/full/empty, per-entry valid and contents
module wb_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  input  wb_req_t                   din,
  output wb_req_t                   dout,
  output logic [CW-1:0]             count,
  output logic                      full,
  output logic                      empty,
  output logic [DEPTH-1:0]          valid,
  output wb_req_t [DEPTH-1:0]       entries
);
  logic [AW-1:0] wp, rp;
  wb_req_t [DEPTH-1:0] mem;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rp];
  assign entries = mem;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      valid <= '0;
    end else begin
      if (do_pop) begin
        rp <= rp + 1'b1;
        valid[rp] <= 1'b0;
      end
      if (do_push) begin
        wp <= wp + 1'b1;
        valid[wp] <= 1'b1;
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
endmodule

// File: rtl/wb_writer.sv
// wb_writer: merges ALU and buffered LSU results onto the register-file write port; ports: ALU/LSU valid-ready request inputs, we/write_reg/write_data outputs, lsu_pending/lsu_count status
module wb_writer
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN,
  parameter int REG_COUNT = riscv_pkg::REG_COUNT,
  parameter int LSU_DEPTH = 4,
  localparam int RW = $clog2(REG_COUNT),
  localparam int CW = $clog2(LSU_DEPTH) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 alu_valid_i,
  input  logic [RW-1:0]        alu_rd_i,
  input  logic [XLEN-1:0]      alu_data_i,
  output logic                 alu_ready_o,
  input  logic                 lsu_valid_i,
  input  logic [RW-1:0]        lsu_rd_i,
  input  logic [XLEN-1:0]      lsu_data_i,
  output logic                 lsu_ready_o,
  output logic                 we_o,
  output logic [RW-1:0]        write_reg_o,
  output logic [XLEN-1:0]      write_data_o,
  output logic [REG_COUNT-1:0] lsu_pending_o,
  output logic [CW-1:0]        lsu_count_o
);
  wb_req_t head, sel;
  wb_req_t [LSU_DEPTH-1:0] entries;
  logic [LSU_DEPTH-1:0] valid;
  logic full, empty, alu_take, push, pop, issue;
  wb_fifo #(.DEPTH(LSU_DEPTH)) u_fifo (
    .clk(clk_i),
    .rst(rst_i),
    .push(push),
    .pop(pop),
    .din('{rd: lsu_rd_i, data: lsu_data_i}),
    .dout(head),
    .count(lsu_count_o),
    .full(full),
    .empty(empty),
    .valid(valid),
    .entries(entries)
  );
  // Ready depends only on occupancy; a full FIFO stalls the ALU so the head can drain.
  assign lsu_ready_o = !full;
  assign alu_ready_o = !full;
  assign alu_take = alu_valid_i && alu_ready_o;
  assign push = lsu_valid_i && lsu_ready_o && lsu_rd_i != '0;
  // An accepted ALU result owns the write slot even when it targets x0.
  assign pop = !alu_take && !empty;
  assign issue = alu_take ? alu_rd_i != '0 : pop;
  assign sel = alu_take ? '{rd: alu_rd_i, data: alu_data_i} : head;
  always_comb begin
    lsu_pending_o = '0;
    for (int i = 0; i < LSU_DEPTH; i++)
      if (valid[i]) lsu_pending_o[entries[i].rd] = 1'b1;
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      we_o <= 1'b0;
      write_reg_o <= '0;
      write_data_o <= '0;
    end else begin
      we_o <= issue;
      if (issue) begin
        write_reg_o <= sel.rd;
        write_data_o <= sel.data;
      end
    end
endmodule

// File: tb/tb_wb_writer.sv
// tb_wb_writer: table-driven check of wb_writer priority, x0 drop, buffering, stall, wrap and reset
module tb_wb_writer;
  logic clk, rst_i;
  logic alu_valid_i, lsu_valid_i, alu_ready_o, lsu_ready_o, we_o;
  logic [4:0] alu_rd_i, lsu_rd_i, write_reg_o;
  logic [31:0] alu_data_i, lsu_data_i, write_data_o, lsu_pending_o;
  logic [2:0] lsu_count_o;
  int checks = 0, errors = 0;
  typedef struct {
    bit av; logic [4:0] ar; logic [31:0] ad;
    bit lv; logic [4:0] lr; logic [31:0] ld;
    bit e_we; logic [4:0] e_reg; logic [31:0] e_data;
    int e_cnt; logic [31:0] e_pend; bit e_rdy;
  } vec_t;
  vec_t vecs[$];
  wb_writer dut (
    .clk_i(clk), .rst_i(rst_i),
    .alu_valid_i(alu_valid_i), .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i), .alu_ready_o(alu_ready_o),
    .lsu_valid_i(lsu_valid_i), .lsu_rd_i(lsu_rd_i), .lsu_data_i(lsu_data_i), .lsu_ready_o(lsu_ready_o),
    .we_o(we_o), .write_reg_o(write_reg_o), .write_data_o(write_data_o),
    .lsu_pending_o(lsu_pending_o), .lsu_count_o(lsu_count_o)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic drive(input bit av, input logic [4:0] ar, input logic [31:0] ad,
                       input bit lv, input logic [4:0] lr, input logic [31:0] ld);
    alu_valid_i = av; alu_rd_i = ar; alu_data_i = ad;
    lsu_valid_i = lv; lsu_rd_i = lr; lsu_data_i = ld;
  endtask
  initial begin
    rst_i = 1;
    drive(0, 0, 0, 0, 0, 0);
    //          av ar  ad           lv lr  ld     we reg data         cnt pend      rdy
    vecs.push_back('{1, 5, 32'hDEADBEEF, 0, 0, 0,    1, 5, 32'hDEADBEEF, 0, 32'h0,    1});
    vecs.push_back('{0, 0, 0,            0, 0, 0,    0, 5, 32'hDEADBEEF, 0, 32'h0,    1});
    vecs.push_back('{1, 0, 32'h1234,     1, 0, 32'h1234, 0, 5, 32'hDEADBEEF, 0, 32'h0, 1});
    vecs.push_back('{1, 3, 32'h33,       1, 7, 32'hA, 1, 3, 32'h33,     1, 32'h80,   1});
    vecs.push_back('{1, 3, 32'h34,       0, 0, 0,    1, 3, 32'h34,       1, 32'h80,   1});
    vecs.push_back('{0, 0, 0,            0, 0, 0,    1, 7, 32'hA,        0, 32'h0,    1});
    vecs.push_back('{0, 0, 0,            0, 0, 0,    0, 7, 32'hA,        0, 32'h0,    1});
    vecs.push_back('{1, 10, 32'h100,     1, 1, 32'h11, 1, 10, 32'h100,   1, 32'h2,    1});
    vecs.push_back('{1, 10, 32'h101,     1, 2, 32'h12, 1, 10, 32'h101,   2, 32'h6,    1});
    vecs.push_back('{1, 10, 32'h102,     1, 3, 32'h13, 1, 10, 32'h102,   3, 32'hE,    1});
    vecs.push_back('{1, 10, 32'h103,     1, 4, 32'h14, 1, 10, 32'h103,   4, 32'h1E,   0});
    vecs.push_back('{1, 10, 32'h104,     1, 5, 32'h15, 1, 1, 32'h11,     3, 32'h1C,   1});
    vecs.push_back('{1, 10, 32'h104,     1, 5, 32'h15, 1, 10, 32'h104,   4, 32'h3C,   0});
    vecs.push_back('{1, 10, 32'h105,     1, 6, 32'h16, 1, 2, 32'h12,     3, 32'h38,   1});
    vecs.push_back('{1, 10, 32'h105,     0, 0, 0,    1, 10, 32'h105,     3, 32'h38,   1});
    vecs.push_back('{0, 0, 0,            0, 0, 0,    1, 3, 32'h13,       2, 32'h30,   1});
    vecs.push_back('{0, 0, 0,            1, 9, 32'h19, 1, 4, 32'h14,     2, 32'h220,  1});
    vecs.push_back('{0, 0, 0,            1, 11, 32'h1B, 1, 5, 32'h15,    2, 32'hA00,  1});
    vecs.push_back('{0, 0, 0,            1, 12, 32'h1C, 1, 9, 32'h19,    2, 32'h1800, 1});
    vecs.push_back('{0, 0, 0,            1, 13, 32'h1D, 1, 11, 32'h1B,   2, 32'h3000, 1});
    vecs.push_back('{0, 0, 0,            0, 0, 0,    1, 12, 32'h1C,      1, 32'h2000, 1});
    vecs.push_back('{0, 0, 0,            0, 0, 0,    1, 13, 32'h1D,      0, 32'h0,    1});
    vecs.push_back('{0, 0, 0,            0, 0, 0,    0, 13, 32'h1D,      0, 32'h0,    1});
    repeat (2) @(negedge clk);
    check("reset_we", we_o, 0);
    check("reset_count", lsu_count_o, 0);
    rst_i = 0;
    foreach (vecs[i]) begin
      drive(vecs[i].av, vecs[i].ar, vecs[i].ad, vecs[i].lv, vecs[i].lr, vecs[i].ld);
      @(negedge clk);
      check($sformatf("v%0d_we", i), we_o, vecs[i].e_we);
      check($sformatf("v%0d_reg", i), write_reg_o, vecs[i].e_reg);
      check($sformatf("v%0d_data", i), write_data_o, vecs[i].e_data);
      check($sformatf("v%0d_count", i), lsu_count_o, vecs[i].e_cnt);
      check($sformatf("v%0d_pending", i), lsu_pending_o, vecs[i].e_pend);
      check($sformatf("v%0d_lsu_ready", i), lsu_ready_o, vecs[i].e_rdy);
      check($sformatf("v%0d_alu_ready", i), alu_ready_o, vecs[i].e_rdy);
    end
    drive(1, 0, 32'h0, 1, 1, 32'h51);
    @(negedge clk);
    drive(1, 0, 32'h0, 1, 2, 32'h52);
    @(negedge clk);
    drive(1, 6, 32'h66, 1, 3, 32'h53);
    @(negedge clk);
    check("pre_rst_count", lsu_count_o, 3);
    check("pre_rst_we", we_o, 1);
    check("pre_rst_pending", lsu_pending_o, 32'hE);
    drive(0, 0, 0, 0, 0, 0);
    rst_i = 1;
    #1;
    check("rst_count", lsu_count_o, 0);
    check("rst_we", we_o, 0);
    check("rst_pending", lsu_pending_o, 0);
    check("rst_reg", write_reg_o, 0);
    check("rst_data", write_data_o, 0);
    @(negedge clk);
    rst_i = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("post_rst%0d_we", k), we_o, 0);
      check($sformatf("post_rst%0d_count", k), lsu_count_o, 0);
    end
    drive(1, 8, 32'h88, 0, 0, 0);
    @(negedge clk);
    check("resume_we", we_o, 1);
    check("resume_reg", write_reg_o, 8);
    check("resume_data", write_data_o, 32'h88);
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("resume_we_drop", we_o, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_writer.md
Name: wb_writer

Overview:
- Writeback-stage initiator that drives the register file's single write port: we, write register index, write data.
- Merges two result sources:
  - the ALU path, one result per cycle when not stalled;
  - the load/store unit (LSU), multi-cycle and bursty, buffered in a small in-order FIFO.
- Issues at most one register write per cycle and drops writes to x0.
- Exports a pending-register mask so decode can stall on read-after-write against buffered loads.

Parameters:
- XLEN, 32, data width of a register.
- REG_COUNT, 32, number of architectural registers; index width RW = $clog2(REG_COUNT).
- LSU_DEPTH, 4, LSU result FIFO entries (power of two, >= 2).

Ports:
- clk_i  input  1  clock; all state updates on posedge.
- rst_i  input  1  asynchronous, active-high reset.
- alu_valid_i  input  1  ALU result present this cycle.
- alu_rd_i  input  RW  ALU destination register.
- alu_data_i  input  XLEN  ALU result.
- alu_ready_o  output  1  ALU result accepted this cycle; upstream holds when low.
- lsu_valid_i  input  1  LSU result present.
- lsu_rd_i  input  RW  LSU destination register.
- lsu_data_i  input  XLEN  LSU result.
- lsu_ready_o  output  1  FIFO can accept an LSU result.
- we_o  output  1  register file write enable.
- write_reg_o  output  RW  register file write index.
- write_data_o  output  XLEN  register file write data.
- lsu_pending_o  output  REG_COUNT  bit r set while any valid FIFO entry targets register r.
- lsu_count_o  output  $clog2(LSU_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (async, active-high): count, read pointer and write pointer = 0; we_o = 0; write_reg_o = 0; write_data_o = 0; lsu_pending_o = 0. A reset mid-operation discards all buffered LSU results. No write issues in the cycle reset deasserts.
- lsu_ready_o = (count < LSU_DEPTH). Combinational from state only, never from valid inputs.
- alu_ready_o = (count < LSU_DEPTH). When the FIFO is full the ALU is stalled so the FIFO head can drain; this is the anti-starvation rule.
- LSU accept: lsu_valid_i && lsu_ready_o.
  - If lsu_rd_i != 0, the entry is pushed at the write pointer.
  - If lsu_rd_i == 0, the handshake completes but nothing is pushed.
- Issue select, evaluated each cycle:
  - (a) alu_valid_i && alu_ready_o: issue the ALU result. If alu_rd_i == 0 the result is accepted but no write is issued, and the FIFO does not pop.
  - (b) else if count > 0: pop the FIFO head and issue it.
  - (c) else: no write.
- FIFO pop rules:
  - A valid ALU result with rd = 0 still takes the slot; the FIFO pops only when the ALU is invalid or stalled.
  - When full, (a) is blocked by alu_ready_o = 0, so (b) pops.
- Output register: on posedge, we_o <= issue; write_reg_o/write_data_o <= the selected rd/data when issuing, otherwise they hold their previous values. Latency is 1 cycle from acceptance to we_o, and we_o is high for exactly one cycle per write. The register file commits on the following negedge.
- Simultaneous push and pop in one cycle (not full): both occur, count unchanged. Push while full is impossible, since ready is low.
- Pointers wrap modulo LSU_DEPTH. count ranges 0..LSU_DEPTH.
- lsu_pending_o:
  - Combinational OR over valid entries of onehot(entry.rd).
  - Cleared for register r the cycle after its last entry pops, i.e. the same edge at which we_o rises for that write.
- Ordering: no ordering is enforced between ALU and LSU results targeting the same rd. Decode stalls on lsu_pending_o[rs/rd], so that case does not arise.
- No combinational path from any *_valid_i to any *_ready_o.

Decomposition:
- Shared package riscv_pkg: XLEN, REG_COUNT, RW localparam, and typedef wb_req_t {logic [RW-1:0] rd; logic [XLEN-1:0] data;}. The ALU, LSU and writeback paths all use it.
- One sub-module: wb_fifo. It is a parameterised LSU_DEPTH x wb_req_t FIFO with push/pop, count, full/empty, and a per-entry valid vector used to build lsu_pending_o.

Test Plan:
- Reset: assert rst_i mid-stream with 3 entries buffered -> immediately count = 0, we_o = 0, lsu_pending_o = 0; after release, no write until a new valid arrives.
- ALU-only: alu rd = 5, data = 0xDEADBEEF, valid one cycle -> next cycle we_o = 1, write_reg_o = 5, write_data_o = 0xDEADBEEF; following cycle we_o = 0.
- x0 drop: alu rd = 0 and lsu rd = 0 both valid with data 0x1234 -> both accepted, we_o stays 0, count stays 0.
- Priority and buffering: LSU pushes rd = 7/0xA while ALU streams rd = 3 every cycle -> ALU writes issue each cycle; lsu_pending_o[7] = 1; write rd = 7 issues the first cycle ALU is idle, then lsu_pending_o[7] = 0.
- Full/starvation: LSU pushes 4 entries (rd 1..4) with ALU continuously valid -> count = 4, lsu_ready_o = 0 and alu_ready_o = 0; the head (rd = 1) writes; ready reasserts; ALU resumes; entries retire in order 1, 2, 3, 4 across stall windows.
- Simultaneous push and pop: count = 2, ALU idle, LSU valid rd = 9 -> head pops and rd = 9 pushes in the same cycle, count stays 2; pointers wrap after 4 more pushes with data intact.
